// File: rtl/bank_pkg.sv
// Shared opcodes, line-state encoding, FSM state type and SRAM geometry for the bank SRAM controller.
package bank_pkg;

    localparam int SRAM_AW = 7;
    localparam int IDX_W   = SRAM_AW - 1;

    localparam logic [2:0] SC_OP_WRITE     = 3'd0;
    localparam logic [2:0] SC_OP_READ      = 3'd1;
    localparam logic [2:0] SC_OP_LINEFILL  = 3'd2;
    localparam logic [2:0] SC_OP_WRITEBACK = 3'd3;

    localparam logic [1:0] LINE_STATE_DIRTY = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        WBRD,
        WR,
        RD,
        RDCAP,
        LF0,
        LF1,
        WB0,
        WB1,
        WBCAP,
        RESP,
        WBOUT
    } sc_state_e;

    function automatic logic is_dirty(input logic [1:0] line_state);
        return line_state == LINE_STATE_DIRTY;
    endfunction

endpackage

// File: rtl/bank_sc_resp_reg.sv
// One-entry valid/ready output register; payload is held stable until the consumer takes it.
module bank_sc_resp_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    // A load may only coincide with an empty or draining entry; the controller guarantees this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: executes one issued write/read/linefill/writeback against the bank data SRAM.
// Optional BANK_SC_RESP_SKID_EN: the response drains from its own register while the FSM returns to IDLE.
module bank_sram_ctrl
    import bank_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int NCH    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  iq_sc_valid_i,
    output logic                  iq_sc_ready_o,
    input  logic [2:0]            iq_sc_opcode_i,
    input  logic [1:0]            iq_sc_channel_id_i,
    input  logic [2:0]            iq_sc_xbar_rob_num_i,
    input  logic [7:0]            iq_sc_wbuffer_id_i,
    input  logic [SRAM_AW-1:0]    iq_sc_set_way_offset_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
    input  logic [LINE_W/2-1:0]   iq_sc_linefill_data_offset0_i,
    input  logic [LINE_W/2-1:0]   iq_sc_linefill_data_offset1_i,

    output logic                  wbuf_ren_o,
    output logic [7:0]            wbuf_raddr_o,
    input  logic [LINE_W/2-1:0]   wbuf_rdata_i,

    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    output logic [LINE_W/2-1:0]   sram_wdata_o,
    input  logic [LINE_W/2-1:0]   sram_rdata_i,

    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [1:0]            resp_ch_id_o,
    output logic [2:0]            resp_rob_o,
    output logic                  resp_is_write_o,
    output logic [LINE_W/2-1:0]   resp_data_o,

    output logic                  biu_wb_valid_o,
    input  logic                  biu_wb_ready_i,
    output logic [IDX_W-1:0]      biu_wb_idx_o,
    output logic [LINE_W-1:0]     biu_wb_data_o,

    output logic [NCH-1:0]        channel_spw_pop_o
);

    localparam int HALF_W = LINE_W / 2;
    localparam int RESP_W = 2 + 3 + 1 + HALF_W;
    localparam int WB_W   = IDX_W + LINE_W;

    sc_state_e           state;
    logic [1:0]          ch;
    logic [2:0]          rob;
    logic [IDX_W-1:0]    idx;
    logic                off;
    logic                dirty1;
    logic [HALF_W-1:0]   lf0;
    logic [HALF_W-1:0]   lf1;
    logic [HALF_W-1:0]   wb_lo;

    logic                accept;
    logic                resp_fire;
    logic                resp_load;
    logic [RESP_W-1:0]   resp_in;
    logic [RESP_W-1:0]   resp_q;
    logic                wb_load;
    logic [WB_W-1:0]     wb_in;
    logic [WB_W-1:0]     wb_q;

`ifdef BANK_SC_RESP_SKID_EN
    localparam sc_state_e RESP_NEXT = IDLE;
    assign iq_sc_ready_o = rst_ni && (state == IDLE) && (!resp_valid_o || resp_ready_i);
`else
    localparam sc_state_e RESP_NEXT = RESP;
    assign iq_sc_ready_o = rst_ni && (state == IDLE);
`endif

    assign accept    = iq_sc_valid_i && iq_sc_ready_o;
    assign resp_fire = resp_valid_o && resp_ready_i;

    // SRAM/write-buffer strobes are registered on the edge that enters the state using them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            ch           <= '0;
            rob          <= '0;
            idx          <= '0;
            off          <= 1'b0;
            dirty1       <= 1'b0;
            lf0          <= '0;
            lf1          <= '0;
            wb_lo        <= '0;
            wbuf_ren_o   <= 1'b0;
            wbuf_raddr_o <= '0;
            sram_en_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
        end else begin
            wbuf_ren_o <= 1'b0;
            sram_en_o  <= 1'b0;
            sram_we_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch     <= iq_sc_channel_id_i;
                        rob    <= iq_sc_xbar_rob_num_i;
                        idx    <= iq_sc_set_way_offset_i[SRAM_AW-1:1];
                        off    <= iq_sc_set_way_offset_i[0];
                        dirty1 <= is_dirty(iq_sc_cacheline_state_offset1_i);
                        lf0    <= iq_sc_linefill_data_offset0_i;
                        lf1    <= iq_sc_linefill_data_offset1_i;
                        case (iq_sc_opcode_i)
                            SC_OP_WRITE: begin
                                state        <= WBRD;
                                wbuf_ren_o   <= 1'b1;
                                wbuf_raddr_o <= iq_sc_wbuffer_id_i;
                            end
                            SC_OP_READ: begin
                                state       <= RD;
                                sram_en_o   <= 1'b1;
                                sram_addr_o <= iq_sc_set_way_offset_i;
                            end
                            SC_OP_LINEFILL: begin
                                state       <= LF0;
                                sram_en_o   <= !is_dirty(iq_sc_cacheline_state_offset0_i);
                                sram_we_o   <= !is_dirty(iq_sc_cacheline_state_offset0_i);
                                sram_addr_o <= {iq_sc_set_way_offset_i[SRAM_AW-1:1], 1'b0};
                            end
                            SC_OP_WRITEBACK: begin
                                state       <= WB0;
                                sram_en_o   <= 1'b1;
                                sram_addr_o <= {iq_sc_set_way_offset_i[SRAM_AW-1:1], 1'b0};
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                WBRD: begin
                    state       <= WR;
                    sram_en_o   <= 1'b1;
                    sram_we_o   <= 1'b1;
                    sram_addr_o <= {idx, off};
                end
                WR:    state <= RESP_NEXT;
                RD:    state <= RDCAP;
                RDCAP: state <= RESP_NEXT;
                LF0: begin
                    state       <= LF1;
                    sram_en_o   <= !dirty1;
                    sram_we_o   <= !dirty1;
                    sram_addr_o <= {idx, 1'b1};
                end
                LF1:   state <= RESP_NEXT;
                WB0: begin
                    state       <= WB1;
                    sram_en_o   <= 1'b1;
                    sram_addr_o <= {idx, 1'b1};
                end
                WB1: begin
                    state <= WBCAP;
                    wb_lo <= sram_rdata_i;
                end
                WBCAP: state <= WBOUT;
                RESP:  if (resp_fire) state <= IDLE;
                WBOUT: if (biu_wb_valid_o && biu_wb_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            WR:      sram_wdata_o = wbuf_rdata_i;
            LF0:     sram_wdata_o = lf0;
            LF1:     sram_wdata_o = lf1;
            default: sram_wdata_o = '0;
        endcase
    end

    // Linefill answers with the requested offset's fill data even when that offset was dirty.
    always_comb begin
        resp_load = 1'b0;
        resp_in   = '0;
        case (state)
            WR: begin
                resp_load = 1'b1;
                resp_in   = {ch, rob, 1'b1, {HALF_W{1'b0}}};
            end
            RDCAP: begin
                resp_load = 1'b1;
                resp_in   = {ch, rob, 1'b0, sram_rdata_i};
            end
            LF1: begin
                resp_load = 1'b1;
                resp_in   = {ch, rob, 1'b0, (off ? lf1 : lf0)};
            end
            default: ;
        endcase
    end

    assign wb_load = (state == WBCAP);
    assign wb_in   = {idx, sram_rdata_i, wb_lo};

    bank_sc_resp_reg #(.W(RESP_W)) u_resp_reg (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (resp_load),
        .load_data (resp_in),
        .valid     (resp_valid_o),
        .ready     (resp_ready_i),
        .data      (resp_q)
    );

    bank_sc_resp_reg #(.W(WB_W)) u_wb_reg (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (wb_load),
        .load_data (wb_in),
        .valid     (biu_wb_valid_o),
        .ready     (biu_wb_ready_i),
        .data      (wb_q)
    );

    assign resp_ch_id_o    = resp_q[RESP_W-1 -: 2];
    assign resp_rob_o      = resp_q[RESP_W-3 -: 3];
    assign resp_is_write_o = resp_q[HALF_W];
    assign resp_data_o     = resp_q[HALF_W-1:0];

    assign biu_wb_idx_o  = wb_q[WB_W-1 -: IDX_W];
    assign biu_wb_data_o = wb_q[LINE_W-1:0];

    // Channel ids beyond NCH return no credit.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            channel_spw_pop_o[i] = resp_fire && (int'(resp_ch_id_o) == i);
        end
    end

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Scoreboard bench for bank_sram_ctrl with behavioural SRAM and write-buffer models.
module tb_bank_sram_ctrl;

    typedef logic [263:0] val_t;
    typedef struct packed {
        logic [1:0]   ch;
        logic [2:0]   rob;
        logic         wr;
        logic [127:0] data;
    } resp_t;
    typedef struct packed {
        logic [5:0]   idx;
        logic [255:0] data;
    } wb_t;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_LA = {8{16'hAAAA}};
    localparam logic [127:0] PAT_LB = {8{16'hBBBB}};
    localparam logic [127:0] PAT_M6 = {8{16'h6666}};
    localparam logic [127:0] PAT_C0 = {8{16'hC0C0}};
    localparam logic [127:0] PAT_C1 = {8{16'hC1C1}};
    localparam logic [127:0] PAT_WB = 128'h1234;

    logic         clk;
    logic         rst_n;
    logic         iq_sc_valid_i;
    logic         iq_sc_ready_o;
    logic [2:0]   iq_sc_opcode_i;
    logic [1:0]   iq_sc_channel_id_i;
    logic [2:0]   iq_sc_xbar_rob_num_i;
    logic [7:0]   iq_sc_wbuffer_id_i;
    logic [6:0]   iq_sc_set_way_offset_i;
    logic [1:0]   iq_sc_cacheline_state_offset0_i;
    logic [1:0]   iq_sc_cacheline_state_offset1_i;
    logic [127:0] iq_sc_linefill_data_offset0_i;
    logic [127:0] iq_sc_linefill_data_offset1_i;
    logic         wbuf_ren_o;
    logic [7:0]   wbuf_raddr_o;
    logic [127:0] wbuf_rdata_i;
    logic         sram_en_o;
    logic         sram_we_o;
    logic [6:0]   sram_addr_o;
    logic [127:0] sram_wdata_o;
    logic [127:0] sram_rdata_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [1:0]   resp_ch_id_o;
    logic [2:0]   resp_rob_o;
    logic         resp_is_write_o;
    logic [127:0] resp_data_o;
    logic         biu_wb_valid_o;
    logic         biu_wb_ready_i;
    logic [5:0]   biu_wb_idx_o;
    logic [255:0] biu_wb_data_o;
    logic [2:0]   channel_spw_pop_o;

    logic [127:0] mem  [0:127];
    logic [127:0] wbuf [0:255];

    resp_t sb_resp[$];
    wb_t   sb_wb[$];
    resp_t mon_r;
    wb_t   mon_w;
    logic [2:0] exp_pop;

    int n_vec = 0;
    int n_err = 0;

    bank_sram_ctrl #(.LINE_W(256), .NCH(3)) dut (
        .clk_i                           (clk),
        .rst_ni                          (rst_n),
        .iq_sc_valid_i                   (iq_sc_valid_i),
        .iq_sc_ready_o                   (iq_sc_ready_o),
        .iq_sc_opcode_i                  (iq_sc_opcode_i),
        .iq_sc_channel_id_i              (iq_sc_channel_id_i),
        .iq_sc_xbar_rob_num_i            (iq_sc_xbar_rob_num_i),
        .iq_sc_wbuffer_id_i              (iq_sc_wbuffer_id_i),
        .iq_sc_set_way_offset_i          (iq_sc_set_way_offset_i),
        .iq_sc_cacheline_state_offset0_i (iq_sc_cacheline_state_offset0_i),
        .iq_sc_cacheline_state_offset1_i (iq_sc_cacheline_state_offset1_i),
        .iq_sc_linefill_data_offset0_i   (iq_sc_linefill_data_offset0_i),
        .iq_sc_linefill_data_offset1_i   (iq_sc_linefill_data_offset1_i),
        .wbuf_ren_o                      (wbuf_ren_o),
        .wbuf_raddr_o                    (wbuf_raddr_o),
        .wbuf_rdata_i                    (wbuf_rdata_i),
        .sram_en_o                       (sram_en_o),
        .sram_we_o                       (sram_we_o),
        .sram_addr_o                     (sram_addr_o),
        .sram_wdata_o                    (sram_wdata_o),
        .sram_rdata_i                    (sram_rdata_i),
        .resp_valid_o                    (resp_valid_o),
        .resp_ready_i                    (resp_ready_i),
        .resp_ch_id_o                    (resp_ch_id_o),
        .resp_rob_o                      (resp_rob_o),
        .resp_is_write_o                 (resp_is_write_o),
        .resp_data_o                     (resp_data_o),
        .biu_wb_valid_o                  (biu_wb_valid_o),
        .biu_wb_ready_i                  (biu_wb_ready_i),
        .biu_wb_idx_o                    (biu_wb_idx_o),
        .biu_wb_data_o                   (biu_wb_data_o),
        .channel_spw_pop_o               (channel_spw_pop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en_o && sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
        if (sram_en_o && !sram_we_o) sram_rdata_i <= mem[sram_addr_o];
        if (wbuf_ren_o) wbuf_rdata_i <= wbuf[wbuf_raddr_o];
    end

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [2:0] rob,
                         input logic [7:0] wid, input logic [6:0] swo,
                         input logic [1:0] s0, input logic [1:0] s1,
                         input logic [127:0] d0, input logic [127:0] d1);
        int n;
        n = 0;
        iq_sc_valid_i                   = 1'b1;
        iq_sc_opcode_i                  = op;
        iq_sc_channel_id_i              = ch;
        iq_sc_xbar_rob_num_i            = rob;
        iq_sc_wbuffer_id_i              = wid;
        iq_sc_set_way_offset_i          = swo;
        iq_sc_cacheline_state_offset0_i = s0;
        iq_sc_cacheline_state_offset1_i = s1;
        iq_sc_linefill_data_offset0_i   = d0;
        iq_sc_linefill_data_offset1_i   = d1;
        while (!iq_sc_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", val_t'(iq_sc_ready_o), val_t'(1'b1));
        tick();
        iq_sc_valid_i = 1'b0;
    endtask

    // Counts cycles after the handshake until the chosen valid rises; start is the current cycle offset.
    task automatic wait_lat(input string tag, input bit wb, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!(wb ? biu_wb_valid_o : resp_valid_o) && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, val_t'(lat), val_t'(exp_lat));
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid_o && resp_ready_i) begin
            if (sb_resp.size() == 0) begin
                check("resp_unexpected", val_t'(resp_valid_o), val_t'(1'b0));
            end else begin
                mon_r   = sb_resp.pop_front();
                exp_pop = (mon_r.ch < 2'd3) ? (3'b001 << mon_r.ch) : 3'b000;
                check("resp_ch", val_t'(resp_ch_id_o), val_t'(mon_r.ch));
                check("resp_rob", val_t'(resp_rob_o), val_t'(mon_r.rob));
                check("resp_is_write", val_t'(resp_is_write_o), val_t'(mon_r.wr));
                check("resp_data", val_t'(resp_data_o), val_t'(mon_r.data));
                check("resp_pop", val_t'(channel_spw_pop_o), val_t'(exp_pop));
            end
        end else if (channel_spw_pop_o != 3'b000) begin
            check("pop_spurious", val_t'(channel_spw_pop_o), val_t'(3'b000));
        end
        if (rst_n && biu_wb_valid_o && biu_wb_ready_i) begin
            if (sb_wb.size() == 0) begin
                check("wb_unexpected", val_t'(biu_wb_valid_o), val_t'(1'b0));
            end else begin
                mon_w = sb_wb.pop_front();
                check("wb_idx", val_t'(biu_wb_idx_o), val_t'(mon_w.idx));
                check("wb_data", val_t'(biu_wb_data_o), val_t'(mon_w.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[6]   <= PAT_M6;
        mem[11]  <= PAT_A5;
        mem[126] <= PAT_C0;
        mem[127] <= PAT_C1;
        wbuf[9]  <= PAT_WB;
        rst_n = 1'b0;
        iq_sc_valid_i = 1'b0;
        iq_sc_opcode_i = '0;
        iq_sc_channel_id_i = '0;
        iq_sc_xbar_rob_num_i = '0;
        iq_sc_wbuffer_id_i = '0;
        iq_sc_set_way_offset_i = '0;
        iq_sc_cacheline_state_offset0_i = '0;
        iq_sc_cacheline_state_offset1_i = '0;
        iq_sc_linefill_data_offset0_i = '0;
        iq_sc_linefill_data_offset1_i = '0;
        resp_ready_i = 1'b1;
        biu_wb_ready_i = 1'b1;
        repeat (2) tick();
        check("rst_ready", val_t'(iq_sc_ready_o), val_t'(1'b0));
        check("rst_outs", val_t'({wbuf_ren_o, sram_en_o, sram_we_o, resp_valid_o, biu_wb_valid_o, channel_spw_pop_o}), val_t'(0));
        rst_n = 1'b1;
        #1;
        check("rel_ready", val_t'(iq_sc_ready_o), val_t'(1'b1));

        // read idx 5 offset 1 on channel 2
        sb_resp.push_back({2'd2, 3'd4, 1'b0, PAT_A5});
        issue(3'd1, 2'd2, 3'd4, 8'd0, 7'd11, 2'b00, 2'b00, '0, '0);
        check("rd_en_we", val_t'({sram_en_o, sram_we_o}), val_t'(2'b10));
        check("rd_addr", val_t'(sram_addr_o), val_t'(7'd11));
        wait_lat("rd_lat", 1'b0, 1, 3);
        tick();
        check("rd_b2b_ready", val_t'(iq_sc_ready_o), val_t'(1'b1));

        // write from write buffer entry 9 to address 0x0B
        sb_resp.push_back({2'd1, 3'd3, 1'b1, 128'd0});
        issue(3'd0, 2'd1, 3'd3, 8'd9, 7'h0B, 2'b00, 2'b00, '0, '0);
        check("wr_wbuf_rd", val_t'({wbuf_ren_o, wbuf_raddr_o}), val_t'({1'b1, 8'd9}));
        tick();
        check("wr_en_we", val_t'({sram_en_o, sram_we_o}), val_t'(2'b11));
        check("wr_addr", val_t'(sram_addr_o), val_t'(7'h0B));
        check("wr_wdata", val_t'(sram_wdata_o), val_t'(PAT_WB));
        wait_lat("wr_lat", 1'b0, 2, 3);
        tick();

        // read back on channel 3: data from the write, no credit
        sb_resp.push_back({2'd3, 3'd5, 1'b0, PAT_WB});
        issue(3'd1, 2'd3, 3'd5, 8'd0, 7'h0B, 2'b00, 2'b00, '0, '0);
        wait_lat("rd3_lat", 1'b0, 1, 3);
        tick();

        // linefill idx 3, offset 0 dirty, requested offset 0
        sb_resp.push_back({2'd0, 3'd6, 1'b0, PAT_LA});
        issue(3'd2, 2'd0, 3'd6, 8'd0, 7'd6, 2'b10, 2'b00, PAT_LA, PAT_LB);
        check("lf0_skip", val_t'(sram_en_o), val_t'(1'b0));
        tick();
        check("lf1_en_we", val_t'({sram_en_o, sram_we_o}), val_t'(2'b11));
        check("lf1_addr", val_t'(sram_addr_o), val_t'(7'd7));
        check("lf1_wdata", val_t'(sram_wdata_o), val_t'(PAT_LB));
        wait_lat("lf_lat", 1'b0, 2, 3);
        tick();
        check("lf_mem6_kept", val_t'(mem[6]), val_t'(PAT_M6));
        check("lf_mem7", val_t'(mem[7]), val_t'(PAT_LB));

        // writeback idx 63 with the BIU stalled
        biu_wb_ready_i = 1'b0;
        sb_wb.push_back({6'd63, PAT_C1, PAT_C0});
        issue(3'd3, 2'd1, 3'd1, 8'd0, 7'd126, 2'b10, 2'b10, '0, '0);
        check("wb_rd0", val_t'({sram_en_o, sram_we_o, sram_addr_o}), val_t'({2'b10, 7'd126}));
        tick();
        check("wb_rd1", val_t'({sram_en_o, sram_we_o, sram_addr_o}), val_t'({2'b10, 7'd127}));
        wait_lat("wb_lat", 1'b1, 2, 4);
        for (int i = 0; i < 5; i++) begin
            check("wb_hold", val_t'({biu_wb_valid_o, biu_wb_idx_o, biu_wb_data_o}), val_t'({1'b1, 6'd63, PAT_C1, PAT_C0}));
            check("wb_nopop", val_t'({resp_valid_o, channel_spw_pop_o}), val_t'(0));
            tick();
        end
        biu_wb_ready_i = 1'b1;
        tick();
        check("wb_done", val_t'({biu_wb_valid_o, iq_sc_ready_o}), val_t'(2'b01));

        // response stall with a new request waiting
        resp_ready_i = 1'b0;
        sb_resp.push_back({2'd1, 3'd2, 1'b0, PAT_C0});
        issue(3'd1, 2'd1, 3'd2, 8'd0, 7'd126, 2'b00, 2'b00, '0, '0);
        wait_lat("stall_lat", 1'b0, 1, 3);
        iq_sc_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stall_ready", val_t'(iq_sc_ready_o), val_t'(1'b0));
            check("stall_hold", val_t'({resp_valid_o, resp_ch_id_o, resp_rob_o, resp_data_o}), val_t'({1'b1, 2'd1, 3'd2, PAT_C0}));
            tick();
        end
        iq_sc_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        check("stall_release", val_t'({resp_valid_o, iq_sc_ready_o}), val_t'(2'b01));

        // reserved opcode is accepted and dropped
        issue(3'd4, 2'd0, 3'd0, 8'd0, 7'd11, 2'b00, 2'b00, '0, '0);
        check("rsvd_idle", val_t'(iq_sc_ready_o), val_t'(1'b1));
        repeat (3) tick();
        check("rsvd_noresp", val_t'({resp_valid_o, sram_en_o}), val_t'(0));

        // reset in the middle of LF1
        issue(3'd2, 2'd2, 3'd1, 8'd0, 7'd8, 2'b00, 2'b00, PAT_A5, PAT_C1);
        tick();
        check("lf1_active", val_t'(sram_en_o), val_t'(1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst_outs", val_t'({iq_sc_ready_o, wbuf_ren_o, sram_en_o, sram_we_o, sram_addr_o, resp_valid_o, biu_wb_valid_o, channel_spw_pop_o}), val_t'(0));
        check("midrst_data", val_t'({sram_wdata_o, resp_data_o}), val_t'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("midrst_rel_ready", val_t'(iq_sc_ready_o), val_t'(1'b1));
        repeat (4) tick();
        check("midrst_noresp", val_t'({resp_valid_o, iq_sc_ready_o}), val_t'(2'b01));

        // post-reset read of the linefilled offset
        sb_resp.push_back({2'd0, 3'd7, 1'b0, PAT_LB});
        issue(3'd1, 2'd0, 3'd7, 8'd0, 7'd7, 2'b00, 2'b00, '0, '0);
        wait_lat("post_lat", 1'b0, 1, 3);
        repeat (3) tick();

        check("sb_resp_left", val_t'(sb_resp.size()), val_t'(0));
        check("sb_wb_left", val_t'(sb_wb.size()), val_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
